// File: rtl/fb_scanout.sv
// Frame buffer scan-out: raster timing, read addressing and latency-aligned video.
// Define FB_SCANOUT_TEST_PATTERN_EN to add the colour-bar test_pattern input.
module fb_scanout #(
    parameter int   H_ACTIVE   = 1920,
    parameter int   H_FP       = 88,
    parameter int   H_SYNC     = 44,
    parameter int   H_BP       = 148,
    parameter int   V_ACTIVE   = 1080,
    parameter int   V_FP       = 4,
    parameter int   V_SYNC     = 5,
    parameter int   V_BP       = 36,
    parameter int   RD_LATENCY = 0,
    parameter logic HS_POL     = 1'b1,
    parameter logic VS_POL     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    input  logic        test_pattern,
`endif
    output logic        fb_rd_en,
    output logic [20:0] fb_addr,
    input  logic [23:0] fb_data,
    output logic        vid_hsync,
    output logic        vid_vsync,
    output logic        vid_de,
    output logic [23:0] vid_rgb,
    output logic        frame_start,
    output logic        busy
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_S   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_E   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_S   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_E   = VW'(V_ACTIVE + V_FP + V_SYNC);

`ifdef FB_SCANOUT_TEST_PATTERN_EN
    localparam int FW = 29;
    localparam int BAR_W = H_ACTIVE / 8;
`else
    localparam int FW = 4;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_n;
    logic [HW-1:0] h, h_n;
    logic [VW-1:0] v, v_n;
    logic [20:0]   addr_n;
    logic          act, frame_end, start_n, rd_n;
    logic          tp_q, tp_n;
    logic [FW-1:0] cur_f, last_in;
    logic [FW-1:0] pipe [RD_LATENCY+1];

    assign busy      = (state == RUN);
    assign act       = busy && (h < H_ACT) && (v < V_ACT);
    assign frame_end = (h == H_LAST) && (v == V_LAST);

    always_comb begin
        state_n = state;
        h_n     = h;
        v_n     = v;
        addr_n  = fb_addr;
        unique case (state)
            IDLE: begin
                h_n    = '0;
                v_n    = '0;
                addr_n = '0;
                if (enable) state_n = RUN;
            end
            RUN: begin
                if (act) addr_n = fb_addr + 21'd1;
                if (h == H_LAST) begin
                    h_n = '0;
                    if (v == V_LAST) begin
                        v_n    = '0;
                        addr_n = '0;
                        if (!enable) state_n = IDLE;
                    end else begin
                        v_n = v + 1'b1;
                    end
                end else begin
                    h_n = h + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // test_pattern is latched only as a new frame begins
    assign start_n = (state_n == RUN) && ((state == IDLE) || frame_end);
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    assign tp_n = start_n ? test_pattern : tp_q;
`else
    assign tp_n = 1'b0;
`endif
    assign rd_n = (state_n == RUN) && (h_n < H_ACT) && (v_n < V_ACT) && !tp_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            h        <= '0;
            v        <= '0;
            fb_addr  <= '0;
            fb_rd_en <= 1'b0;
            tp_q     <= 1'b0;
        end else begin
            state    <= state_n;
            h        <= h_n;
            v        <= v_n;
            fb_addr  <= addr_n;
            fb_rd_en <= rd_n;
            tp_q     <= tp_n;
        end
    end

`ifdef FB_SCANOUT_TEST_PATTERN_EN
    logic [2:0]  bar;
    logic [23:0] col;

    always_comb begin
        bar = 3'd0;
        for (int i = 1; i < 8; i++)
            if (h >= HW'(i * BAR_W)) bar = 3'(i);
    end

    always_comb begin
        unique case (bar)
            3'd0:    col = 24'hFFFFFF;
            3'd1:    col = 24'hFFFF00;
            3'd2:    col = 24'h00FFFF;
            3'd3:    col = 24'h00FF00;
            3'd4:    col = 24'hFF00FF;
            3'd5:    col = 24'hFF0000;
            3'd6:    col = 24'h0000FF;
            default: col = 24'h000000;
        endcase
    end
`endif

    logic fs_c, hs_c, vs_c;
    assign fs_c = busy && (h == '0) && (v == '0);
    assign hs_c = busy && (h >= HS_S) && (h < HS_E);
    assign vs_c = busy && (v >= VS_S) && (v < VS_E);

`ifdef FB_SCANOUT_TEST_PATTERN_EN
    assign cur_f = {col, tp_q, fs_c, vs_c, hs_c, act};
`else
    assign cur_f = {fs_c, vs_c, hs_c, act};
`endif

    generate
        if (RD_LATENCY == 0) begin : g_l0
            assign last_in = cur_f;
        end else begin : g_ln
            assign last_in = pipe[RD_LATENCY-1];
        end
    endgenerate

    logic [23:0] rgb_sel;
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    assign rgb_sel = last_in[4] ? last_in[28:5] : fb_data;
`else
    assign rgb_sel = fb_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= RD_LATENCY; i++) pipe[i] <= '0;
            vid_rgb <= '0;
        end else begin
            pipe[0] <= cur_f;
            for (int i = 1; i <= RD_LATENCY; i++) pipe[i] <= pipe[i-1];
            vid_rgb <= last_in[0] ? rgb_sel : 24'h0;
        end
    end

    assign vid_de      = pipe[RD_LATENCY][0];
    assign vid_hsync   = pipe[RD_LATENCY][1] ? HS_POL : ~HS_POL;
    assign vid_vsync   = pipe[RD_LATENCY][2] ? VS_POL : ~VS_POL;
    assign frame_start = pipe[RD_LATENCY][3];
endmodule

// File: doc/fb_scanout.md
# fb_scanout

Display scan-out engine that reads the frame buffer and drives a video output. It sits on the read side of the 1920x1080x24-bit frame buffer and generates CEA-861 1080p60 raster timing (2200x1125 total). It issues one pixel read address per active pixel in raster order. It aligns the returned RGB data with registered hsync/vsync/data-enable outputs, compensating for a configurable read latency.

## Interface
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch (pixels)
- H_SYNC, 44, hsync width (pixels)
- H_BP, 148, horizontal back porch (pixels)
- V_ACTIVE, 1080, active lines
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 36, vertical back porch (lines)
- RD_LATENCY, 0, frame buffer read latency in cycles, legal 0..4
- HS_POL, 1, hsync asserted level
- VS_POL, 1, vsync asserted level

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- enable  in  1  request scan-out
- fb_rd_en  out  1  read strobe, high during active pixels
- fb_addr  out  21  pixel index v*H_ACTIVE+h
- fb_data  in  24  pixel RGB {R,G,B}, valid RD_LATENCY cycles after fb_addr
- vid_hsync  out  1  horizontal sync
- vid_vsync  out  1  vertical sync
- vid_de  out  1  data enable
- vid_rgb  out  24  pixel output, 0 when vid_de=0
- frame_start  out  1  one-cycle pulse coincident with first vid_de of a frame
- busy  out  1  state is RUN

Reset: the reset is reset, asynchronous, active-high; the clock is clk.

## Operation
- Derived totals: H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters. Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) are registered.
- States:
  - IDLE: h=v=0, fb_rd_en=0. In IDLE with enable=1, the next state is RUN at position (0,0).
  - RUN: h increments each cycle. At h=H_TOTAL-1, h wraps to 0 and v increments.
  - End of frame: at (H_TOTAL-1, V_TOTAL-1), go to IDLE if enable=0, otherwise wrap to (0,0) and stay in RUN. A frame in progress always completes; enable is sampled only at IDLE and at end of frame.
- Active region: h<H_ACTIVE and v<V_ACTIVE.
- hsync region: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
- vsync region: V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for entire lines.
- Sync output level: asserted = POL, deasserted = ~POL.
- Address generation:
  - fb_addr is a running 21-bit counter, not a multiply. It is 0 at frame position (0,0) and increments after each active pixel.
  - Last address is H_ACTIVE*V_ACTIVE-1 (2073599 at defaults).
  - fb_addr holds its value outside the active region and is reloaded to 0 at frame wrap.
- fb_rd_en and fb_addr are registered alongside h/v and describe the same position.
- Alignment: de, hsync, vsync and frame_start flags travel through a delay line of depth RD_LATENCY+1. vid_rgb is registered from fb_data in the same stage the flags exit.

## Timing
- Values at reset: state IDLE, h=v=0, fb_rd_en=0, fb_addr=0, vid_de=0, vid_rgb=0, vid_hsync=~HS_POL, vid_vsync=~VS_POL, frame_start=0, busy=0. The delay line is cleared to the same inactive values.
- Latency: the position presented on fb_addr in cycle t appears on the vid_* outputs in cycle t+RD_LATENCY+1.
- Start-up: enable rises in IDLE at cycle t. Then busy=1, fb_rd_en=1 and fb_addr=0 in cycle t+1. First vid_de=1 and frame_start=1 occur in cycle t+RD_LATENCY+2.
- Stop: after the final cycle of the last frame, state returns to IDLE. The delay line drains, so outputs become inactive RD_LATENCY+1 cycles later.
- Reset mid-frame: all state returns to reset values immediately; no partial pixel is output after reset deasserts.
- Per-line/frame counts: each line has exactly H_ACTIVE de-high cycles and H_SYNC hsync-asserted cycles. Each frame has exactly V_SYNC*H_TOTAL vsync-asserted cycles.

## Configuration
- Macro: FB_SCANOUT_TEST_PATTERN_EN.
- When defined, the block adds input port test_pattern (1 bit).
- With test_pattern=1:
  - fb_rd_en is held 0 and fb_data is ignored.
  - vid_rgb shows 8 vertical colour bars, each bar H_ACTIVE/8 pixels wide. Order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - The bar colour is computed at the counter stage and delayed with the flags.
  - test_pattern is sampled only at frame start.
- When the macro is undefined, the port is absent and vid_rgb always comes from fb_data.

## Test plan
- Small raster (H 8/2/2/2, V 4/1/1/1, RD_LATENCY=0), enable held high:
  - vid_de high for 8 cycles per line on 4 lines.
  - hsync asserted 2 cycles per 14-cycle line.
  - vsync asserted 14 cycles per 98-cycle frame.
  - fb_addr walks 0..31 and resets to 0 at the next frame.
- Same raster with RD_LATENCY=3 and a memory model returning fb_data=addr: vid_rgb equals 0,1,2,… aligned with vid_de; first vid_de occurs 5 cycles after enable rises.
- Drop enable in the middle of frame 1: frame completes all 98 cycles, busy falls, then outputs go idle with vid_hsync=~HS_POL.
- Assert reset in the middle of an active line: next cycle vid_de=0, vid_rgb=0, fb_addr=0; re-enable restarts at address 0 with frame_start.
- Default 1080p parameters: first frame_start is followed by exactly 2073600 de cycles before the next frame_start, 2475000 cycles apart.
- With FB_SCANOUT_TEST_PATTERN_EN defined and test_pattern=1: pixel 0 is FFFFFF, pixel 240 is FFFF00, pixel 1919 is 000000; fb_rd_en never asserts.
